// File: rtl/toy_host_loader_if.sv
// Bundle of the loader's control, stream and RAM-port signals.
// master = loader side, slave = host/accelerator side.
interface toy_host_loader_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              go;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              toy_start;
  logic              toy_finish;
  logic              mem_owner;
  logic [1:0]        mem_sel;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  go, in_valid, in_data, out_ready, toy_finish, mem_rdata,
    output in_ready, out_valid, out_data, out_last, busy, done, toy_start,
           mem_owner, mem_sel, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output go, in_valid, in_data, out_ready, toy_finish, mem_rdata,
    input  in_ready, out_valid, out_data, out_last, busy, done, toy_start,
           mem_owner, mem_sel, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/toy_host_loader.sv
// Host-side sequencer: streams words into the accelerator's a/b/c RAMs,
// kicks the accelerator, then drains the result region of c as a stream.
module toy_host_loader #(
  parameter int unsigned DEPTH    = 1001,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RD_BASE  = 1,
  parameter int unsigned RD_COUNT = 999
) (
  input  logic                clk,
  input  logic                reset,
  toy_host_loader_if.master   bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, LOAD_C, START, RUN, DRAIN, DONE
  } state_t;

  state_t            state;
  state_t            load_next;
  logic [CNT_W-1:0]  wc;
  logic [CNT_W-1:0]  rp;
  logic [CNT_W-1:0]  ic;
  logic [CNT_W-1:0]  dc;
  logic [DATA_W-1:0] f0;
  logic [DATA_W-1:0] f1;
  logic [1:0]        cnt;
  logic              pend;
  logic [1:0]        sel;

  logic loading;
  logic wr;
  logic rd;
  logic pop;
  logic wc_last;
  logic dc_last;

  assign loading = state inside {LOAD_A, LOAD_B, LOAD_C};
  assign wr      = loading && bus.in_valid;
  assign wc_last = (wc == CNT_W'(DEPTH - 1));
  assign dc_last = (dc == CNT_W'(RD_COUNT - 1));
  assign pop     = (state == DRAIN) && (cnt != 2'd0) && bus.out_ready;
  // A slot freed by this cycle's pop may be refilled, keeping one word per cycle.
  assign rd      = (state == DRAIN) && (ic < CNT_W'(RD_COUNT)) &&
                   ((3'(cnt) + 3'(pend)) < (3'd2 + 3'(pop)));

  always_comb begin
    load_next = START;
    case (state)
      LOAD_A:  load_next = LOAD_B;
      LOAD_B:  load_next = LOAD_C;
      default: load_next = START;
    endcase
  end

  always_comb begin
    sel = 2'd0;
    case (state)
      LOAD_B:        sel = 2'd1;
      LOAD_C, DRAIN: sel = 2'd2;
      default:       sel = 2'd0;
    endcase
  end

  assign bus.in_ready  = loading;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.toy_start = (state == START);
  assign bus.mem_owner = !((state == START) || (state == RUN));
  assign bus.mem_en    = wr || rd;
  assign bus.mem_we    = wr;
  assign bus.mem_sel   = sel;
  assign bus.mem_addr  = wr ? ADDR_W'(wc) : (rd ? ADDR_W'(rp) : '0);
  assign bus.mem_wdata = wr ? bus.in_data : '0;
  assign bus.out_valid = (cnt != 2'd0);
  assign bus.out_data  = f0;
  assign bus.out_last  = (cnt != 2'd0) && dc_last;

  // Sequencer, counters and the two-entry skid FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wc    <= '0;
      rp    <= '0;
      ic    <= '0;
      dc    <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
      f0    <= '0;
      f1    <= '0;
    end else begin
      pend <= rd;
      case (state)
        IDLE: begin
          if (bus.go) begin
            state <= LOAD_A;
            wc    <= '0;
          end
        end
        LOAD_A, LOAD_B, LOAD_C: begin
          if (wr) begin
            if (wc_last) begin
              wc    <= '0;
              state <= load_next;
            end else begin
              wc <= wc + CNT_W'(1);
            end
          end
        end
        START: state <= RUN;
        RUN: begin
          if (bus.toy_finish) begin
            state <= DRAIN;
            rp    <= CNT_W'(RD_BASE);
            ic    <= '0;
            dc    <= '0;
          end
        end
        DRAIN: begin
          if (rd) begin
            rp <= rp + CNT_W'(1);
            ic <= ic + CNT_W'(1);
          end
          if (pop) begin
            dc <= dc + CNT_W'(1);
            if (dc_last) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Read data returns one cycle after issue and is pushed then.
      case ({pend, pop})
        2'b10: begin
          if (cnt == 2'd0) f0 <= bus.mem_rdata;
          else             f1 <= bus.mem_rdata;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          f0  <= f1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            f0 <= bus.mem_rdata;
          end else begin
            f0 <= f1;
            f1 <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
